// File: rtl/utlb_translate.sv
// Data-side micro-TLB: fully-associative even/odd page-pair array with a JTLB
// refill handshake on miss, returning physical address, cache attribute and exceptions.
module utlb_translate #(
    parameter int ENTRIES = 4,
    parameter int PTR_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic        req_store,
    input  logic [7:0]  asid,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_uncached,
    output logic        resp_refill,
    output logic        resp_invalid,
    output logic        resp_modified,
    output logic        jtlb_req_valid,
    output logic [18:0] jtlb_vpn2,
    output logic [7:0]  jtlb_asid,
    input  logic        jtlb_resp_valid,
    input  logic        jtlb_hit,
    input  logic        jtlb_g,
    input  logic [19:0] jtlb_pfn0,
    input  logic [19:0] jtlb_pfn1,
    input  logic [2:0]  jtlb_c0,
    input  logic [2:0]  jtlb_c1,
    input  logic        jtlb_d0,
    input  logic        jtlb_d1,
    input  logic        jtlb_v0,
    input  logic        jtlb_v1
);

    typedef enum logic [1:0] {IDLE, JTLB_WAIT, RESP} state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } entry_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    entry_t             ent_q [ENTRIES];
    entry_t             ent_d [ENTRIES];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        vaddr_q, vaddr_d;
    logic               store_q, store_d;
    logic [7:0]         asid_q, asid_d;
    logic               flush_seen_q, flush_seen_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_paddr_q, resp_paddr_d;
    logic               resp_uncached_q, resp_uncached_d;
    logic               resp_refill_q, resp_refill_d;
    logic               resp_invalid_q, resp_invalid_d;
    logic               resp_modified_q, resp_modified_d;

    logic               hit_any;
    logic [PTR_W-1:0]   hit_idx;
    entry_t             hit_ent;

    // Packs {paddr, uncached, refill, invalid, modified}; refill > invalid > modified.
    function automatic logic [35:0] build_resp(
        input logic        found,
        input logic        v,
        input logic        d,
        input logic [2:0]  c,
        input logic [19:0] pfn,
        input logic        store,
        input logic [11:0] offs
    );
        if (!found)
            return {32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        if (!v)
            return {32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        if (store && !d)
            return {32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        return {pfn, offs, (c == 3'b010), 3'b000};
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (ent_q[i].vpn2 == req_vaddr[31:13]) &&
                (ent_q[i].g || (ent_q[i].asid == asid))) begin
                hit_any = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
        hit_ent = ent_q[hit_idx];
    end

    assign req_ready = (state_q == IDLE) && !flush;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        ent_d           = ent_q;
        ptr_d           = ptr_q;
        vaddr_d         = vaddr_q;
        store_d         = store_q;
        asid_d          = asid_q;
        flush_seen_d    = flush_seen_q;
        resp_valid_d    = 1'b0;
        resp_paddr_d    = 32'h0;
        resp_uncached_d = 1'b0;
        resp_refill_d   = 1'b0;
        resp_invalid_d  = 1'b0;
        resp_modified_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    vaddr_d      = req_vaddr;
                    store_d      = req_store;
                    asid_d       = asid;
                    flush_seen_d = 1'b0;
                    if (hit_any) begin
                        {resp_paddr_d, resp_uncached_d, resp_refill_d,
                         resp_invalid_d, resp_modified_d} = build_resp(
                            1'b1,
                            req_vaddr[12] ? hit_ent.v1   : hit_ent.v0,
                            req_vaddr[12] ? hit_ent.d1   : hit_ent.d0,
                            req_vaddr[12] ? hit_ent.c1   : hit_ent.c0,
                            req_vaddr[12] ? hit_ent.pfn1 : hit_ent.pfn0,
                            req_store, req_vaddr[11:0]);
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = JTLB_WAIT;
                    end
                end
            end
            JTLB_WAIT: begin
                if (flush)
                    flush_seen_d = 1'b1;
                if (jtlb_resp_valid) begin
                    {resp_paddr_d, resp_uncached_d, resp_refill_d,
                     resp_invalid_d, resp_modified_d} = build_resp(
                        jtlb_hit,
                        vaddr_q[12] ? jtlb_v1   : jtlb_v0,
                        vaddr_q[12] ? jtlb_d1   : jtlb_d0,
                        vaddr_q[12] ? jtlb_c1   : jtlb_c0,
                        vaddr_q[12] ? jtlb_pfn1 : jtlb_pfn0,
                        store_q, vaddr_q[11:0]);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                    // A flush anywhere in the miss window makes the refilled entry stale.
                    if (jtlb_hit && !flush_seen_q && !flush) begin
                        ent_d[ptr_q].vpn2 = vaddr_q[31:13];
                        ent_d[ptr_q].asid = asid_q;
                        ent_d[ptr_q].g    = jtlb_g;
                        ent_d[ptr_q].pfn0 = jtlb_pfn0;
                        ent_d[ptr_q].pfn1 = jtlb_pfn1;
                        ent_d[ptr_q].c0   = jtlb_c0;
                        ent_d[ptr_q].c1   = jtlb_c1;
                        ent_d[ptr_q].d0   = jtlb_d0;
                        ent_d[ptr_q].d1   = jtlb_d1;
                        ent_d[ptr_q].v0   = jtlb_v0;
                        ent_d[ptr_q].v1   = jtlb_v1;
                        valid_d[ptr_q]    = 1'b1;
                        ptr_d             = ptr_q + 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush)
            valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            ptr_q           <= '0;
            flush_seen_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_paddr_q    <= 32'h0;
            resp_uncached_q <= 1'b0;
            resp_refill_q   <= 1'b0;
            resp_invalid_q  <= 1'b0;
            resp_modified_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            ptr_q           <= ptr_d;
            flush_seen_q    <= flush_seen_d;
            resp_valid_q    <= resp_valid_d;
            resp_paddr_q    <= resp_paddr_d;
            resp_uncached_q <= resp_uncached_d;
            resp_refill_q   <= resp_refill_d;
            resp_invalid_q  <= resp_invalid_d;
            resp_modified_q <= resp_modified_d;
        end
        vaddr_q <= vaddr_d;
        store_q <= store_d;
        asid_q  <= asid_d;
        ent_q   <= ent_d;
    end

    assign jtlb_req_valid = (state_q == JTLB_WAIT);
    assign jtlb_vpn2      = jtlb_req_valid ? vaddr_q[31:13] : 19'h0;
    assign jtlb_asid      = jtlb_req_valid ? asid_q : 8'h0;
    assign resp_valid     = resp_valid_q;
    assign resp_paddr     = resp_paddr_q;
    assign resp_uncached  = resp_uncached_q;
    assign resp_refill    = resp_refill_q;
    assign resp_invalid   = resp_invalid_q;
    assign resp_modified  = resp_modified_q;

endmodule
